// File: rtl/lcd_responder.sv
// HD44780-style LCD bus responder: 32-character DDRAM, address counter, entry mode and busy flag.
// Optional feature: define LCD_RESP_BUSY_EN to model busy timing and overrun detection.
module lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        lcd_en,
  input  logic        lcd_rs,
  input  logic        lcd_rw,
  input  logic [7:0]  lcd_data_in,
  output logic [7:0]  lcd_data_out,
  output logic        lcd_data_oe,
  input  logic [4:0]  dbg_addr,
  output logic [7:0]  dbg_char,
  output logic        display_on,
  output logic        busy,
  output logic        err_overrun,
  output logic [15:0] write_count
);

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_CLEAR,
    CMD_HOME,
    CMD_ENTRY,
    CMD_DISPLAY,
    CMD_SET_AC
  } cmd_e;

  logic [7:0] ddram [32];
  logic [6:0] ac;
  logic       id;
  logic       en_q;
  logic       en_stale;
  logic       fall;
  logic       wr_fall;
  logic       rd_fall;
  logic       wr_accept;
  logic       write_block;
  cmd_e       cmd;
  logic       ac_valid;
  logic [4:0] ac_idx;
  logic [6:0] ac_next;
  logic [7:0] rd_char;

  // Handshake: a transaction is one lcd_en high-then-low pulse. The clock on which
  // lcd_en is low after a registered high is the single valid beat, and rs/rw/data
  // are taken on that beat. There is no ready: reads are always serviced, writes
  // landing while write_block is high are dropped and flagged as overruns.
  assign fall      = en_q & ~lcd_en;
  assign wr_fall   = fall & ~lcd_rw;
  assign rd_fall   = fall & lcd_rw;
  assign wr_accept = wr_fall & ~write_block;

  assign ac_valid = (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
  assign ac_idx   = {ac[6], ac[3:0]};
  assign rd_char  = ac_valid ? ddram[ac_idx] : 8'h20;

  // Line 1 (0x00-0x0F) and line 2 (0x40-0x4F) form one 32-entry ring.
  always_comb begin
    ac_next = 7'h00;
    if (ac_valid) begin
      if (id) begin
        case (ac)
          7'h0F:   ac_next = 7'h40;
          7'h4F:   ac_next = 7'h00;
          default: ac_next = ac + 7'd1;
        endcase
      end else begin
        case (ac)
          7'h40:   ac_next = 7'h0F;
          7'h00:   ac_next = 7'h4F;
          default: ac_next = ac - 7'd1;
        endcase
      end
    end
  end

  always_comb begin
    cmd = CMD_NOP;
    casez (lcd_data_in)
      8'b1???????: cmd = CMD_SET_AC;
      8'b01??????: cmd = CMD_NOP;
      8'b001?????: cmd = CMD_NOP;
      8'b0001????: cmd = CMD_NOP;
      8'b00001???: cmd = CMD_DISPLAY;
      8'b000001??: cmd = CMD_ENTRY;
      8'b0000001?: cmd = CMD_HOME;
      8'b00000001: cmd = CMD_CLEAR;
      default:     cmd = CMD_NOP;
    endcase
  end

  // en_stale swallows a pulse that was already high when reset was applied.
  always_ff @(posedge clock) begin
    if (reset) begin
      en_q        <= 1'b0;
      en_stale    <= lcd_en;
      ac          <= 7'h00;
      id          <= 1'b1;
      display_on  <= 1'b0;
      write_count <= 16'h0000;
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
    end else begin
      en_q     <= lcd_en & ~en_stale;
      en_stale <= en_stale & lcd_en;
      if (wr_accept) begin
        write_count <= write_count + 16'd1;
        if (lcd_rs) begin
          if (ac_valid) ddram[ac_idx] <= lcd_data_in;
          ac <= ac_next;
        end else begin
          case (cmd)
            CMD_CLEAR: begin
              for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
              ac <= 7'h00;
              id <= 1'b1;
            end
            CMD_HOME:    ac <= 7'h00;
            CMD_ENTRY:   id <= lcd_data_in[1];
            CMD_DISPLAY: display_on <= lcd_data_in[2];
            CMD_SET_AC:  ac <= lcd_data_in[6:0];
            default:     ;
          endcase
        end
      end else if (rd_fall && lcd_rs) begin
        ac <= ac_next;
      end
    end
  end

`ifdef LCD_RESP_BUSY_EN
  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             long_cmd;

  assign long_cmd = ~lcd_rs && ((cmd == CMD_CLEAR) || (cmd == CMD_HOME));

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      if (wr_accept) begin
        busy_cnt <= long_cmd ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
      end else if (busy_cnt != '0) begin
        busy_cnt <= busy_cnt - CNT_W'(1);
      end
      if (wr_fall && write_block) err_overrun <= 1'b1;
    end
  end

  assign busy        = (busy_cnt != '0);
  // A write on the clock where the counter steps 1 -> 0 is still accepted.
  assign write_block = (busy_cnt > CNT_W'(1));
`else
  logic unused_busy_cfg;
  assign unused_busy_cfg = ^{BUSY_CYCLES, CLEAR_CYCLES};
  assign busy            = 1'b0;
  assign err_overrun     = 1'b0;
  assign write_block     = 1'b0;
`endif

  assign lcd_data_oe  = lcd_en & lcd_rw & ~reset;
  assign lcd_data_out = lcd_data_oe ? (lcd_rs ? rd_char : {busy, ac}) : 8'h00;
  assign dbg_char     = ddram[dbg_addr];

endmodule

// File: tb/tb_lcd_responder.sv
// Bench for lcd_responder: directed vector table, multi-cycle corner sequences and
// randomized traffic checked against a behavioural model of the LCD controller.
module tb_lcd_responder;

  localparam int BUSY_N  = 16;
  localparam int CLEAR_N = 60;
`ifdef LCD_RESP_BUSY_EN
  localparam bit BUSY_EN = 1'b1;
`else
  localparam bit BUSY_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data_in;
  logic [7:0]  lcd_data_out;
  logic        lcd_data_oe;
  logic [4:0]  dbg_addr;
  logic [7:0]  dbg_char;
  logic        display_on;
  logic        busy;
  logic        err_overrun;
  logic [15:0] write_count;

  lcd_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .clock(clock), .reset(reset), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .dbg_addr(dbg_addr), .dbg_char(dbg_char), .display_on(display_on), .busy(busy),
    .err_overrun(err_overrun), .write_count(write_count)
  );

  // clock / reset
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // behavioural model: DDRAM as a linear 32-entry ring, busy as an absolute deadline
  logic [7:0]  m_mem [32];
  logic [6:0]  m_ac;
  bit          m_id;
  bit          m_disp;
  bit          m_err;
  logic [15:0] m_wc;
  int          m_busy_until;

  function automatic int ac_to_idx(input logic [6:0] a);
    int v = int'(a);
    if (v < 16) return v;
    if (v >= 64 && v < 80) return v - 48;
    return -1;
  endfunction

  function automatic logic [6:0] idx_to_ac(input int i);
    return 7'((i < 16) ? i : i + 48);
  endfunction

  function automatic bit m_busy();
    return cyc < m_busy_until;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
    m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0; m_err = 1'b0; m_wc = 16'h0; m_busy_until = 0;
  endtask

  task automatic m_step();
    int i = ac_to_idx(m_ac);
    if (i < 0) m_ac = 7'h00;
    else m_ac = idx_to_ac(m_id ? (i + 1) % 32 : (i + 31) % 32);
  endtask

  function automatic logic [7:0] m_read(input bit rs);
    int i = ac_to_idx(m_ac);
    if (rs) return (i < 0) ? 8'h20 : m_mem[i];
    return {m_busy(), m_ac};
  endfunction

  task automatic m_txn(input bit rs, input bit rw, input logic [7:0] d, input int when);
    int dur = BUSY_N;
    int i;
    if (rw) begin
      if (rs) m_step();
    end else if (BUSY_EN && when < m_busy_until) begin
      m_err = 1'b1;
    end else begin
      m_wc++;
      if (rs) begin
        i = ac_to_idx(m_ac);
        if (i >= 0) m_mem[i] = d;
        m_step();
      end else if (d[7]) m_ac = d[6:0];
      else if (d[6:4] != 3'b000) begin end
      else if (d[3]) m_disp = d[2];
      else if (d[2]) m_id = d[1];
      else if (d[1]) begin m_ac = 7'h00; dur = CLEAR_N; end
      else if (d[0]) begin
        for (int j = 0; j < 32; j++) m_mem[j] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1; dur = CLEAR_N;
      end
      if (BUSY_EN) m_busy_until = when + dur;
    end
  endtask

  // driver: en rises at a negedge, bus sampled hold negedges later, fall seen at the next posedge
  task automatic txn(input bit rs, input bit rw, input logic [7:0] d, input int hold,
                     output logic [7:0] rd_val, output logic rd_oe, output logic [7:0] exp_rd);
    @(negedge clock);
    lcd_rs = rs; lcd_rw = rw; lcd_data_in = d; lcd_en = 1'b1;
    repeat (hold) @(negedge clock);
    rd_val = lcd_data_out; rd_oe = lcd_data_oe; exp_rd = m_read(rs);
    lcd_en = 1'b0;
    @(posedge clock); #1;
    m_txn(rs, rw, d, cyc);
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0; m_reset();
    @(posedge clock); #1;
  endtask

  task automatic peek_char(input string name, input int idx, input logic [7:0] exp);
    dbg_addr = 5'(idx); #1;
    check(name, dbg_char, exp);
  endtask

  function automatic logic [7:0] rand_instr();
    logic [7:0] v;
    case ($urandom_range(0, 9))
      0: v = 8'h01;
      1: v = 8'h02 | 8'($urandom_range(0, 1));
      2: v = 8'h04 | 8'($urandom_range(0, 3));
      3: v = 8'h08 | 8'($urandom_range(0, 7));
      4: v = 8'h20 | 8'($urandom_range(0, 31));
      5: v = 8'h40 | 8'($urandom_range(0, 63));
      6: v = 8'h00;
      default: begin
        v = {1'b1, 1'($urandom_range(0, 1)), 2'b00, 4'($urandom_range(0, 15))};
        if ($urandom_range(0, 7) == 0) v = 8'h80 | 8'($urandom_range(0, 127));
      end
    endcase
    return v;
  endfunction

  typedef struct {
    bit          rs;
    bit          rw;
    logic [7:0]  din;
    logic [7:0]  exp_rd;
    bit          chk;
    logic [4:0]  addr;
    logic [7:0]  exp_char;
    logic [15:0] exp_wc;
    bit          exp_disp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] rv;
  logic [7:0] rexp;
  logic       roe;
  int         k;

  initial begin
    reset = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_data_in = 8'h00; dbg_addr = 5'd0;
    m_reset();
    //            rs rw din    rd     chk addr char   wc  disp
    vecs.push_back('{0, 0, 8'h80, 8'h00, 0, 0,  8'h00, 1,  0});
    vecs.push_back('{1, 0, 8'h41, 8'h00, 1, 0,  8'h41, 2,  0});
    vecs.push_back('{0, 1, 8'h00, 8'h01, 0, 0,  8'h00, 2,  0});
    vecs.push_back('{0, 0, 8'h8F, 8'h00, 0, 0,  8'h00, 3,  0});
    vecs.push_back('{1, 0, 8'h42, 8'h00, 1, 15, 8'h42, 4,  0});
    vecs.push_back('{1, 0, 8'h43, 8'h00, 1, 16, 8'h43, 5,  0});
    vecs.push_back('{0, 1, 8'h00, 8'h41, 0, 0,  8'h00, 5,  0});
    vecs.push_back('{0, 0, 8'h04, 8'h00, 0, 0,  8'h00, 6,  0});
    vecs.push_back('{0, 0, 8'h80, 8'h00, 0, 0,  8'h00, 7,  0});
    vecs.push_back('{1, 0, 8'h44, 8'h00, 1, 0,  8'h44, 8,  0});
    vecs.push_back('{0, 1, 8'h00, 8'h4F, 0, 0,  8'h00, 8,  0});
    vecs.push_back('{0, 0, 8'h06, 8'h00, 0, 0,  8'h00, 9,  0});
    vecs.push_back('{0, 0, 8'h0C, 8'h00, 0, 0,  8'h00, 10, 1});
    vecs.push_back('{0, 0, 8'hC5, 8'h00, 0, 0,  8'h00, 11, 1});
    vecs.push_back('{1, 1, 8'h00, 8'h20, 0, 0,  8'h00, 11, 1});
    vecs.push_back('{0, 1, 8'h00, 8'h46, 0, 0,  8'h00, 11, 1});
    vecs.push_back('{0, 0, 8'h8F, 8'h00, 0, 0,  8'h00, 12, 1});
    vecs.push_back('{1, 1, 8'h00, 8'h42, 0, 0,  8'h00, 12, 1});
    vecs.push_back('{0, 1, 8'h00, 8'h40, 0, 0,  8'h00, 12, 1});
    vecs.push_back('{0, 0, 8'h90, 8'h00, 0, 0,  8'h00, 13, 1});
    vecs.push_back('{1, 0, 8'h55, 8'h00, 1, 0,  8'h44, 14, 1});
    vecs.push_back('{0, 1, 8'h00, 8'h00, 0, 0,  8'h00, 14, 1});
    vecs.push_back('{0, 0, 8'hCF, 8'h00, 0, 0,  8'h00, 15, 1});
    vecs.push_back('{1, 0, 8'h66, 8'h00, 1, 31, 8'h66, 16, 1});
    vecs.push_back('{0, 1, 8'h00, 8'h00, 0, 0,  8'h00, 16, 1});
    vecs.push_back('{0, 0, 8'h08, 8'h00, 0, 0,  8'h00, 17, 0});
    vecs.push_back('{0, 0, 8'h00, 8'h00, 0, 0,  8'h00, 18, 0});
    vecs.push_back('{0, 0, 8'h3F, 8'h00, 0, 0,  8'h00, 19, 0});
    vecs.push_back('{0, 0, 8'h7F, 8'h00, 0, 0,  8'h00, 20, 0});
    vecs.push_back('{0, 1, 8'h00, 8'h00, 0, 0,  8'h00, 20, 0});
    vecs.push_back('{0, 0, 8'h04, 8'h00, 0, 0,  8'h00, 21, 0});
    vecs.push_back('{0, 0, 8'hC0, 8'h00, 0, 0,  8'h00, 22, 0});
    vecs.push_back('{1, 0, 8'h77, 8'h00, 1, 16, 8'h77, 23, 0});
    vecs.push_back('{0, 1, 8'h00, 8'h0F, 0, 0,  8'h00, 23, 0});

    repeat (3) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;

    // reset state
    check("rst_wc", write_count, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_overrun, 0);
    check("rst_disp", display_on, 0);
    check("rst_oe", lcd_data_oe, 0);
    check("rst_dout", lcd_data_out, 0);
    for (int i = 0; i < 32; i += 5) peek_char("rst_ddram", i, 8'h20);

    // directed vector table
    foreach (vecs[i]) begin
      txn(vecs[i].rs, vecs[i].rw, vecs[i].din, 1, rv, roe, rexp);
      if (vecs[i].rw) begin
        check($sformatf("vec%0d_rd", i), rv, vecs[i].exp_rd);
        check($sformatf("vec%0d_oe", i), roe, 1);
      end
      check($sformatf("vec%0d_wc", i), write_count, vecs[i].exp_wc);
      check($sformatf("vec%0d_disp", i), display_on, vecs[i].exp_disp);
      check($sformatf("vec%0d_busy", i), busy, BUSY_EN && !vecs[i].rw);
      if (vecs[i].chk) peek_char($sformatf("vec%0d_char", i), vecs[i].addr, vecs[i].exp_char);
      repeat (CLEAR_N + 2) @(posedge clock);
      #1;
    end
    check("tbl_err", err_overrun, 0);

    // clear, then a data write 10 clocks later
    txn(0, 0, 8'h01, 1, rv, roe, rexp);
    k = cyc;
    check("clr_busy", busy, BUSY_EN);
    txn(1, 0, 8'h58, 9, rv, roe, rexp);
    check("clr_wc", write_count, BUSY_EN ? 24 : 25);
    check("clr_err", err_overrun, BUSY_EN);
    check("clr_busy_mid", busy, BUSY_EN);
    repeat (CLEAR_N) @(posedge clock);
    #1;
    check("clr_busy_end", busy, 0);
    for (int i = 0; i < 32; i++) peek_char("clr_ddram", i, (i == 0 && !BUSY_EN) ? 8'h58 : 8'h20);

    // write landing exactly as the counter expires, then one clock too early
    do_reset();
    txn(0, 0, 8'h80, 1, rv, roe, rexp);
    txn(1, 0, 8'h61, BUSY_N - 1, rv, roe, rexp);
    check("edge_wc", write_count, 2);
    check("edge_err", err_overrun, 0);
    peek_char("edge_char", 0, 8'h61);
    txn(1, 0, 8'h62, BUSY_N - 2, rv, roe, rexp);
    check("early_wc", write_count, BUSY_EN ? 2 : 3);
    check("early_err", err_overrun, BUSY_EN);
    peek_char("early_char", 1, BUSY_EN ? 8'h20 : 8'h62);

    // reset while a transaction is in flight
    repeat (CLEAR_N + 2) @(posedge clock);
    txn(0, 0, 8'h0C, 1, rv, roe, rexp);
    repeat (CLEAR_N + 2) @(posedge clock);
    txn(0, 0, 8'h04, 1, rv, roe, rexp);
    repeat (CLEAR_N + 2) @(posedge clock);
    check("pre_disp", display_on, 1);
    @(negedge clock);
    lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_data_in = 8'h99; lcd_en = 1'b1;
    @(negedge clock); reset = 1'b1;
    #1;
    check("midrst_oe", lcd_data_oe, 0);
    check("midrst_dout", lcd_data_out, 0);
    @(negedge clock); lcd_rw = 1'b0;
    @(negedge clock); reset = 1'b0; m_reset();
    @(negedge clock);
    @(negedge clock); lcd_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("midrst_wc", write_count, 0);
    check("midrst_disp", display_on, 0);
    check("midrst_err", err_overrun, 0);
    check("midrst_busy", busy, 0);
    peek_char("midrst_c0", 0, 8'h20);
    peek_char("midrst_c1", 1, 8'h20);
    txn(1, 0, 8'h31, 1, rv, roe, rexp);
    repeat (CLEAR_N + 2) @(posedge clock);
    txn(0, 1, 8'h00, 1, rv, roe, rexp);
    check("midrst_ac", rv, 8'h01);
    peek_char("midrst_c0w", 0, 8'h31);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 250; n++) begin
      int op = $urandom_range(0, 9);
      bit rs;
      bit rw;
      logic [7:0] d;
      int a;
      repeat ($urandom_range(0, BUSY_N + 3)) @(posedge clock);
      rs = (op <= 3) || (op >= 7 && op <= 8);
      rw = (op >= 6 && op <= 8);
      d  = rs ? 8'($urandom_range(0, 255)) : (op == 9 ? 8'($urandom_range(0, 255)) : rand_instr());
      txn(rs, rw, d, $urandom_range(1, 3), rv, roe, rexp);
      check($sformatf("rnd%0d_oe", n), roe, rw);
      check($sformatf("rnd%0d_dout", n), rv, rw ? rexp : 8'h00);
      check($sformatf("rnd%0d_wc", n), write_count, m_wc);
      check($sformatf("rnd%0d_err", n), err_overrun, m_err);
      check($sformatf("rnd%0d_disp", n), display_on, m_disp);
      check($sformatf("rnd%0d_busy", n), busy, m_busy());
      a = $urandom_range(0, 31);
      peek_char($sformatf("rnd%0d_char%0d", n, a), a, m_mem[a]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
